bp_be_lce_req_arbiter: RTL
==========================

# bp_be_lce_req_arbiter

Round-robin arbiter that shares one outgoing LCE request link between several LCE request sources in the back end (I-cache LCE, D-cache LCE). It holds a 2-entry output buffer, so requester-side ready never depends combinationally on downstream `lce_req_ready_i`. It sits between the cache LCEs and the core's `lce_req_o`/`lce_req_v_o`/`lce_req_ready_i` boundary. It exposes an idle flag for fence/quiesce logic.

## Interface
- `num_req_p`, default 2: number of requesters, at least 2.
- `data_width_p`, default `lce_cce_req_width_lp`: request packet width.
- `lg_num_req_lp`, localparam, `$clog2(num_req_p)`: width of the priority pointer.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `reset_n_i` in 1: reset, asynchronous assert, active-low.
- `req_data_i` in `num_req_p*data_width_p`: requester packets; requester *i* occupies bits `[i*data_width_p +: data_width_p]`.
- `req_v_i` in `num_req_p`: per-requester valid.
- `req_ready_o` out `num_req_p`: per-requester ready. Handshake completes when `v & ready`.
- `lce_req_o` out `data_width_p`: packet at the buffer head.
- `lce_req_v_o` out 1: buffer head valid.
- `lce_req_ready_i` in 1: downstream ready. Handshake completes when `lce_req_v_o & lce_req_ready_i`.
- `idle_o` out 1: buffer empty and no `req_v_i` asserted.

## Operation
- State:
  - 2-entry FIFO with read pointer, write pointer and count (0..2).
  - Priority pointer `prio_r` (0..`num_req_p`-1).
- Grant (combinational):
  - Scan requesters starting at `prio_r`, wrapping modulo `num_req_p`.
  - The first one with `req_v_i` set is granted.
  - At most one bit of `grant` is set.
- Ready rule:
  - `req_ready_o[i] = grant[i] & (count != 2)`.
  - Ready depends on `req_v_i` and on registered state only, never on `lce_req_ready_i`.
  - A requester whose valid is low sees ready low.
- Enqueue: `enq = |(req_v_i & req_ready_o)`. The granted packet is written at the write pointer.
- Dequeue: `deq = lce_req_v_o & lce_req_ready_i`.
- Count update:
  - count += `enq` − `deq`.
  - With count = 1, enqueue and dequeue in the same cycle leave count at 1.
  - With count = 2, enqueue is blocked (ready low) even if a dequeue happens that cycle. No bypass: the freed slot is usable the next cycle.
- Priority update:
  - On `enq` from requester *k*, `prio_r` becomes (*k*+1) mod `num_req_p`.
  - With no `enq`, `prio_r` holds. A requester stalled by a full buffer does not lose its turn.
- Outputs:
  - `lce_req_v_o = (count != 0)`.
  - `lce_req_o` = head entry.
  - Head data is stable while `lce_req_v_o` is high and not dequeued.
- Sources may drop `req_v_i` before ready; the arbiter keeps no lock and no per-source state.
- `idle_o = (count == 0) & ~|req_v_i`.

## Timing
- Reset (asynchronous, `reset_n_i` low):
  - count = 0, pointers = 0, `prio_r` = 0, storage cleared to 0.
  - `lce_req_v_o` = 0, `lce_req_o` = 0.
  - `req_ready_o` = `grant` (buffer empty).
  - `idle_o` = `~|req_v_i`.
- Reset mid-operation discards buffered packets immediately. Packets already handshaken are lost, which is acceptable because the whole LCE network resets together.
- Release is synchronous to `clk_i`. The first enqueue can happen on the first rising edge after release.
- Latency: packet accepted at edge *t* appears on `lce_req_o` with `lce_req_v_o` = 1 from *t* to the next edge, i.e. 1 cycle.
- Throughput:
  - 1 packet/cycle sustained while `lce_req_ready_i` stays high.
  - With downstream stalled, two packets are accepted, then `req_ready_o` goes low.
- Wrap: FIFO pointers are 1 bit each and wrap 1→0. `prio_r` wraps `num_req_p`−1 → 0.

## Test plan
Settings: `num_req_p`=2, `data_width_p`=8.
- **Reset values:** hold `reset_n_i`=0 mid-run with 2 entries buffered.
  - Required: `lce_req_v_o`=0 and `lce_req_o`=0 immediately, without a clock edge.
  - After release with `req_v_i`=2'b00: `idle_o`=1.
- **Alternation:** both valid continuously (`req0`=0xA0.., `req1`=0xB0..), `lce_req_ready_i`=1.
  - Required output stream: 0xA0, 0xB0, 0xA1, 0xB1, …, one per cycle, first valid 1 cycle after the first accept.
- **Backpressure:** `lce_req_ready_i`=0, `req0` valid with 0x11, 0x22, 0x33.
  - Required: 0x11 and 0x22 accepted, then `req_ready_o[0]`=0 and 0x33 held.
  - Raise `lce_req_ready_i`: 0x11 dequeues. 0x33 is accepted the next cycle, not the same cycle. Order out: 0x11, 0x22, 0x33.
- **Simultaneous enq/deq at count=1:** count stays 1 across 10 cycles of continuous traffic; `lce_req_v_o` stays 1 and no packet is dropped or duplicated.
- **Fairness under stall:** `prio_r`=1, buffer full, both valid.
  - Required: while full, both readies are 0.
  - On the first free slot, `req1` is granted first and `prio_r` becomes 0.
- **Single source:** only `req1` valid.
  - Required: granted every cycle regardless of `prio_r`. `req_ready_o[0]` stays 0.
  - `idle_o`=1 once `req1` drops and the buffer drains.

Source files
------------

// File: rtl/bp_be_lce_req_arbiter.sv
// bp_be_lce_req_arbiter
// Round-robin arbiter merging several back-end LCE request sources onto one
// outgoing LCE request link. A 2-entry output buffer decouples requester-side
// ready from the downstream ready, so no combinational path runs from
// lce_req_ready_i to req_ready_o.

module bp_be_lce_req_arbiter #(
    parameter int num_req_p    = 2,
    // Normally overridden with lce_cce_req_width_lp by the instantiating core.
    parameter int data_width_p = 8
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,

    input  logic [num_req_p*data_width_p-1:0] req_data_i,
    input  logic [num_req_p-1:0]              req_v_i,
    output logic [num_req_p-1:0]              req_ready_o,

    output logic [data_width_p-1:0]           lce_req_o,
    output logic                              lce_req_v_o,
    input  logic                              lce_req_ready_i,

    output logic                              idle_o
);

    localparam int lg_num_req_lp = $clog2(num_req_p);

    // Buffer state: two storage slots, 1-bit read/write pointers, occupancy 0..2.
    logic [data_width_p-1:0]  mem_q [2];
    logic [data_width_p-1:0]  mem_d [2];
    logic                     rptr_q, rptr_d;
    logic                     wptr_q, wptr_d;
    logic [1:0]               count_q, count_d;

    // Round-robin pointer: the requester that gets first look next cycle.
    logic [lg_num_req_lp-1:0] prio_q, prio_d;

    logic [num_req_p-1:0]     grant;
    logic [lg_num_req_lp-1:0] grantIdx;
    logic [data_width_p-1:0]  grantData;
    logic                     found;
    logic                     bufFull;
    logic                     enq;
    logic                     deq;

    // Scan from prio_q upward first, then wrap around from requester 0; the
    // first valid requester found wins, so at most one grant bit is ever set.
    always_comb begin
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        for (int j = 0; j < num_req_p; j++) begin
            if (!found && (j >= int'(prio_q)) && req_v_i[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                grantIdx = lg_num_req_lp'(j);
            end
        end
        for (int j = 0; j < num_req_p; j++) begin
            if (!found && req_v_i[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                grantIdx = lg_num_req_lp'(j);
            end
        end
    end

    // Select the granted requester's packet for writing into the buffer.
    always_comb begin
        grantData = '0;
        for (int j = 0; j < num_req_p; j++) begin
            if (grant[j]) begin
                grantData = req_data_i[j*data_width_p +: data_width_p];
            end
        end
    end

    // Handshakes. Ready only looks at registered occupancy, never at the
    // downstream ready, so a slot freed this cycle is only offered next cycle.
    always_comb begin
        bufFull     = (count_q == 2'd2);
        req_ready_o = grant & {num_req_p{~bufFull}};
        enq         = |(req_v_i & req_ready_o);
        lce_req_v_o = (count_q != 2'd0);
        deq         = lce_req_v_o & lce_req_ready_i;
        lce_req_o   = mem_q[rptr_q];
        idle_o      = (count_q == 2'd0) & ~|req_v_i;
    end

    // Next-state for buffer contents, pointers, occupancy and round-robin
    // pointer. A stalled requester keeps its turn because prio only moves
    // on an actual enqueue.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        prio_d  = prio_q;

        if (enq) begin
            mem_d[wptr_q] = grantData;
            wptr_d        = ~wptr_q;
            if (grantIdx == lg_num_req_lp'(num_req_p - 1)) begin
                prio_d = '0;
            end else begin
                prio_d = grantIdx + 1'b1;
            end
        end

        if (deq) begin
            rptr_d = ~rptr_q;
        end

        case ({enq, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards anything buffered immediately.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rptr_q   <= 1'b0;
            wptr_q   <= 1'b0;
            count_q  <= 2'd0;
            prio_q   <= '0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            count_q  <= count_d;
            prio_q   <= prio_d;
        end
    end

endmodule
